ones_frame_accumulator: RTL and testbench
=========================================

Name: ones_frame_accumulator

Overview:
- Sits directly downstream of the 8-bit ones-count stage.
- Consumes one 4-bit per-byte ones count per beat over a valid/ready handshake and sums the counts across a frame.
- At frame end, presents the frame total, the byte count and status flags on an output valid/ready handshake.
- Used for line-density and DC-balance monitoring on byte streams.

Parameters:
- SUM_W, 12, width of the frame total; the total saturates at 2^SUM_W-1.
- MAX_BYTES, 256, beats per frame before a forced close (minimum 1).
- THRESH, 1024, density threshold; dense is asserted when sum_out >= THRESH.
- BC_W, 9, byte-count width; must satisfy 2^BC_W > MAX_BYTES.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cnt_in  in  4  per-byte ones count from the upstream counter; legal range 0..8.
- cnt_valid  in  1  cnt_in and last are valid.
- last  in  1  this beat closes the frame.
- cnt_ready  out  1  block accepts a beat this cycle.
- sum_out  out  SUM_W  frame total of ones.
- byte_cnt  out  BC_W  beats accepted in the frame.
- dense  out  1  sum_out >= THRESH.
- sat  out  1  total saturated during the frame.
- bad_in  out  1  at least one beat had cnt_in > 8.
- forced  out  1  frame closed by MAX_BYTES, not by last.
- sum_valid  out  1  result fields are valid.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- Reset, sampled at a clk edge with rst=1:
  - state goes to IDLE.
  - Internal accumulator, beat counter and sticky flags clear.
  - All registered outputs go to 0: sum_out, byte_cnt, dense, sat, bad_in, forced, sum_valid.
  - cnt_ready is 1 in the first cycle after reset.
  - Reset overrides everything, including a mid-frame accumulation or a held result; a partial frame is discarded and never output.
- States:
  - IDLE: no beats accepted in the current frame.
  - ACCUM: at least one beat accepted, frame still open.
  - HOLD: result presented.
- cnt_ready = (state != HOLD). It is combinational from state only and never depends on cnt_valid.
- Beat accept = cnt_valid & cnt_ready.
- On each accepted beat:
  - Effective count e = (cnt_in > 8) ? 8 : cnt_in.
  - If cnt_in > 8, the bad_in sticky bit is set.
  - acc_next = acc + e. If this exceeds 2^SUM_W-1, acc_next = 2^SUM_W-1 and the sat sticky bit is set.
  - The beat counter increments by 1.
- Frame close is a beat accepted with last=1, or the accepted beat that makes the beat counter equal MAX_BYTES.
  - forced = 1 only when MAX_BYTES is reached and last=0 on that beat.
  - If last=1 on the MAX_BYTES-th beat, forced = 0.
- On the close edge:
  - sum_out, byte_cnt, sat, bad_in and forced load their final values, including the closing beat.
  - dense = (final sum >= THRESH).
  - sum_valid goes to 1 and the state moves to HOLD.
  - Latency: the closing beat accepted at edge k gives sum_valid=1 in the cycle after edge k.
- Non-closing beats: IDLE moves to ACCUM; ACCUM stays in ACCUM.
- HOLD:
  - All result outputs stay stable while sum_valid=1 and out_ready=0.
  - cnt_ready=0; cnt_valid is ignored.
  - On sum_valid & out_ready at edge m: sum_valid=0 after m, state moves to IDLE, and the accumulator, counter and sticky bits clear.
  - The result outputs keep their last values; only sum_valid qualifies them.
  - cnt_ready=1 in the cycle after m. There is no same-cycle accept and release.
- out_ready is ignored when sum_valid=0.
- cnt_valid=0 cycles in IDLE or ACCUM leave all state unchanged; there is no timeout.
- Minimum frame length is 1 beat; a frame can never be output with byte_cnt=0.
- Throughput: one beat per cycle while accumulating; at least one dead input cycle per frame, plus any downstream stall.

Test Plan:
1. Reset, then one beat cnt_in=6 with last=1, out_ready=1. Expect sum_valid=1 the next cycle with sum_out=6, byte_cnt=1, dense=0, sat=bad_in=forced=0; one cycle later sum_valid=0 and cnt_ready=1.
2. THRESH=24, beats 8,8,8,8 with last on the 4th, then beat 3. Expect sum_out=32, byte_cnt=4, dense=1. The following frame starts from 0: the single-beat frame 3 with last gives sum_out=3.
3. Backpressure: complete a frame of beats 1,2,3 (last on 3), then hold out_ready=0 for 5 cycles. Expect sum_out=6 stable and cnt_ready=0 throughout, with a beat offered during HOLD not counted. Raise out_ready: the result is consumed once.
4. MAX_BYTES=4, SUM_W=5: beats 8,8,8,8 with last=0 throughout. Expect a forced close after the 4th beat with sum_out=31, sat=1, forced=1, byte_cnt=4. Repeat with last=1 on the 4th beat: forced=0.
5. Beats 12,2 (last on 2). Expect sum_out=10 and bad_in=1.
6. Beats 5,5, then rst=1 for one cycle, then a beat 7 with last. Expect no result for the aborted frame, and sum_out=7 with byte_cnt=1. Also assert rst while in HOLD: expect sum_valid=0 after reset.

Source files
------------

// File: rtl/ones_frame_accumulator.sv
// Sums per-byte ones counts across a frame and presents the total, the beat count
// and the status flags on an output valid/ready handshake.
module ones_frame_accumulator #(
  parameter int SUM_W     = 12,
  parameter int MAX_BYTES = 256,
  parameter int THRESH    = 1024,
  parameter int BC_W      = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        cnt_in,
  input  logic              cnt_valid,
  input  logic              last,
  output logic              cnt_ready,
  output logic [SUM_W-1:0]  sum_out,
  output logic [BC_W-1:0]   byte_cnt,
  output logic              dense,
  output logic              sat,
  output logic              bad_in,
  output logic              forced,
  output logic              sum_valid,
  input  logic              out_ready
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [BC_W-1:0] MAX_BC   = BC_W'(MAX_BYTES);
  localparam logic [31:0]     THRESH_U = 32'(THRESH);

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [BC_W-1:0]    beats_q, beats_d;
  logic               sat_acc_q, sat_acc_d;
  logic               bad_acc_q, bad_acc_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [BC_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic               dense_q, dense_d;
  logic               sat_q, sat_d;
  logic               bad_q, bad_d;
  logic               forced_q, forced_d;
  logic               sum_valid_q, sum_valid_d;

  logic               accept;
  logic               bad_now;
  logic [3:0]         eff;
  logic [SUM_W:0]     sum_wide;
  logic               sat_now;
  logic [SUM_W-1:0]   acc_new;
  logic [BC_W-1:0]    beats_new;
  logic               max_hit;

  assign cnt_ready = (state_q != HOLD);
  assign accept    = cnt_valid & cnt_ready;

  // Counts above 8 are impossible for a byte, so they are clamped and flagged.
  assign bad_now   = (cnt_in > 4'd8);
  assign eff       = bad_now ? 4'd8 : cnt_in;
  assign sum_wide  = {1'b0, acc_q} + (SUM_W+1)'(eff);
  assign sat_now   = sum_wide[SUM_W];
  assign acc_new   = sat_now ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];
  assign beats_new = beats_q + 1'b1;
  assign max_hit   = (beats_new == MAX_BC);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beats_d     = beats_q;
    sat_acc_d   = sat_acc_q;
    bad_acc_d   = bad_acc_q;
    sum_d       = sum_q;
    byte_cnt_d  = byte_cnt_q;
    dense_d     = dense_q;
    sat_d       = sat_q;
    bad_d       = bad_q;
    forced_d    = forced_q;
    sum_valid_d = sum_valid_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d     = acc_new;
          beats_d   = beats_new;
          sat_acc_d = sat_acc_q | sat_now;
          bad_acc_d = bad_acc_q | bad_now;
          if (last || max_hit) begin
            sum_d       = acc_new;
            byte_cnt_d  = beats_new;
            dense_d     = (32'(acc_new) >= THRESH_U);
            sat_d       = sat_acc_q | sat_now;
            bad_d       = bad_acc_q | bad_now;
            forced_d    = max_hit & ~last;
            sum_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        // Result fields keep their values after release; only sum_valid drops.
        if (out_ready) begin
          sum_valid_d = 1'b0;
          acc_d       = '0;
          beats_d     = '0;
          sat_acc_d   = 1'b0;
          bad_acc_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      beats_q     <= '0;
      sat_acc_q   <= 1'b0;
      bad_acc_q   <= 1'b0;
      sum_q       <= '0;
      byte_cnt_q  <= '0;
      dense_q     <= 1'b0;
      sat_q       <= 1'b0;
      bad_q       <= 1'b0;
      forced_q    <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beats_q     <= beats_d;
      sat_acc_q   <= sat_acc_d;
      bad_acc_q   <= bad_acc_d;
      sum_q       <= sum_d;
      byte_cnt_q  <= byte_cnt_d;
      dense_q     <= dense_d;
      sat_q       <= sat_d;
      bad_q       <= bad_d;
      forced_q    <= forced_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign sum_out   = sum_q;
  assign byte_cnt  = byte_cnt_q;
  assign dense     = dense_q;
  assign sat       = sat_q;
  assign bad_in    = bad_q;
  assign forced    = forced_q;
  assign sum_valid = sum_valid_q;

endmodule

// File: tb/tb_ones_frame_accumulator.sv
// Directed bench: instance a uses wide sums with THRESH=24; instance b uses
// SUM_W=5, MAX_BYTES=4 to reach saturation and forced frame closes.
module tb_ones_frame_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  a_cnt_in = '0;
  logic        a_cnt_valid = 1'b0, a_last = 1'b0, a_out_ready = 1'b0;
  logic        a_cnt_ready, a_dense, a_sat, a_bad_in, a_forced, a_sum_valid;
  logic [11:0] a_sum_out;
  logic [8:0]  a_byte_cnt;

  logic [3:0]  b_cnt_in = '0;
  logic        b_cnt_valid = 1'b0, b_last = 1'b0, b_out_ready = 1'b0;
  logic        b_cnt_ready, b_dense, b_sat, b_bad_in, b_forced, b_sum_valid;
  logic [4:0]  b_sum_out;
  logic [2:0]  b_byte_cnt;

  ones_frame_accumulator #(.SUM_W(12), .MAX_BYTES(256), .THRESH(24), .BC_W(9)) dut_a (
    .clk(clk), .rst(rst), .cnt_in(a_cnt_in), .cnt_valid(a_cnt_valid), .last(a_last),
    .cnt_ready(a_cnt_ready), .sum_out(a_sum_out), .byte_cnt(a_byte_cnt), .dense(a_dense),
    .sat(a_sat), .bad_in(a_bad_in), .forced(a_forced), .sum_valid(a_sum_valid),
    .out_ready(a_out_ready)
  );

  ones_frame_accumulator #(.SUM_W(5), .MAX_BYTES(4), .THRESH(24), .BC_W(3)) dut_b (
    .clk(clk), .rst(rst), .cnt_in(b_cnt_in), .cnt_valid(b_cnt_valid), .last(b_last),
    .cnt_ready(b_cnt_ready), .sum_out(b_sum_out), .byte_cnt(b_byte_cnt), .dense(b_dense),
    .sat(b_sat), .bad_in(b_bad_in), .forced(b_forced), .sum_valid(b_sum_valid),
    .out_ready(b_out_ready)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Outputs are sampled and inputs driven on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic a_beat(input logic [3:0] c, input logic l);
    a_cnt_in = c; a_last = l; a_cnt_valid = 1'b1;
    cyc();
  endtask

  task automatic b_beat(input logic [3:0] c, input logic l);
    b_cnt_in = c; b_last = l; b_cnt_valid = 1'b1;
    cyc();
  endtask

  initial begin
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_sum_valid", 32'(a_sum_valid), 0);
    chk("rst_sum_out", 32'(a_sum_out), 0);
    chk("rst_byte_cnt", 32'(a_byte_cnt), 0);
    chk("rst_flags", {28'd0, a_dense, a_sat, a_bad_in, a_forced}, 0);
    chk("rst_cnt_ready", 32'(a_cnt_ready), 1);

    // 1: single-beat frame
    a_out_ready = 1'b1;
    a_beat(4'd6, 1'b1);
    a_cnt_valid = 1'b0;
    chk("t1_valid", 32'(a_sum_valid), 1);
    chk("t1_sum", 32'(a_sum_out), 6);
    chk("t1_bytes", 32'(a_byte_cnt), 1);
    chk("t1_flags", {28'd0, a_dense, a_sat, a_bad_in, a_forced}, 0);
    chk("t1_ready_hold", 32'(a_cnt_ready), 0);
    cyc();
    chk("t1_released", 32'(a_sum_valid), 0);
    chk("t1_ready_back", 32'(a_cnt_ready), 1);

    // 2: dense frame, then the next frame starts from zero
    a_beat(4'd8, 1'b0);
    chk("t2_mid_valid", 32'(a_sum_valid), 0);
    a_beat(4'd8, 1'b0);
    a_beat(4'd8, 1'b0);
    a_beat(4'd8, 1'b1);
    a_cnt_valid = 1'b0;
    chk("t2_valid", 32'(a_sum_valid), 1);
    chk("t2_sum", 32'(a_sum_out), 32);
    chk("t2_bytes", 32'(a_byte_cnt), 4);
    chk("t2_dense", 32'(a_dense), 1);
    chk("t2_sat", 32'(a_sat), 0);
    cyc();
    a_beat(4'd3, 1'b1);
    a_cnt_valid = 1'b0;
    chk("t2_next_sum", 32'(a_sum_out), 3);
    chk("t2_next_bytes", 32'(a_byte_cnt), 1);
    chk("t2_next_dense", 32'(a_dense), 0);
    cyc();

    // 3: backpressure, beats offered during HOLD are ignored
    a_out_ready = 1'b0;
    a_beat(4'd1, 1'b0);
    a_beat(4'd2, 1'b0);
    a_beat(4'd3, 1'b1);
    a_cnt_in = 4'd5;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_sum", 32'(a_sum_out), 6);
      chk("t3_hold_valid", 32'(a_sum_valid), 1);
      chk("t3_hold_ready", 32'(a_cnt_ready), 0);
      cyc();
    end
    chk("t3_bytes", 32'(a_byte_cnt), 3);
    a_cnt_valid = 1'b0;
    a_out_ready = 1'b1;
    cyc();
    chk("t3_consumed", 32'(a_sum_valid), 0);
    chk("t3_sum_kept", 32'(a_sum_out), 6);
    cyc();
    chk("t3_once", 32'(a_sum_valid), 0);

    // 5: out-of-range count is clamped to 8 and flagged
    a_beat(4'd12, 1'b0);
    a_beat(4'd2, 1'b1);
    a_cnt_valid = 1'b0;
    chk("t5_sum", 32'(a_sum_out), 10);
    chk("t5_bad", 32'(a_bad_in), 1);
    chk("t5_bytes", 32'(a_byte_cnt), 2);
    cyc();

    // 6: reset mid-frame discards the partial frame
    a_beat(4'd5, 1'b0);
    a_beat(4'd5, 1'b0);
    a_cnt_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_abort_valid", 32'(a_sum_valid), 0);
    chk("t6_abort_sum", 32'(a_sum_out), 0);
    a_out_ready = 1'b0;
    a_beat(4'd7, 1'b1);
    a_cnt_valid = 1'b0;
    chk("t6_sum", 32'(a_sum_out), 7);
    chk("t6_bytes", 32'(a_byte_cnt), 1);
    chk("t6_bad", 32'(a_bad_in), 0);
    cyc();
    chk("t6_held", 32'(a_sum_valid), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_hold_rst_valid", 32'(a_sum_valid), 0);
    chk("t6_hold_rst_ready", 32'(a_cnt_ready), 1);

    // 4: forced close with saturation on the small instance
    b_out_ready = 1'b1;
    b_beat(4'd8, 1'b0);
    b_beat(4'd8, 1'b0);
    b_beat(4'd8, 1'b0);
    chk("t4_open", 32'(b_sum_valid), 0);
    b_beat(4'd8, 1'b0);
    b_cnt_valid = 1'b0;
    chk("t4_valid", 32'(b_sum_valid), 1);
    chk("t4_sum", 32'(b_sum_out), 31);
    chk("t4_sat", 32'(b_sat), 1);
    chk("t4_forced", 32'(b_forced), 1);
    chk("t4_bytes", 32'(b_byte_cnt), 4);
    chk("t4_dense", 32'(b_dense), 1);
    cyc();
    chk("t4_released", 32'(b_sum_valid), 0);
    b_beat(4'd8, 1'b0);
    b_beat(4'd8, 1'b0);
    b_beat(4'd8, 1'b0);
    b_beat(4'd8, 1'b1);
    b_cnt_valid = 1'b0;
    chk("t4b_valid", 32'(b_sum_valid), 1);
    chk("t4b_forced", 32'(b_forced), 0);
    chk("t4b_sat", 32'(b_sat), 1);
    chk("t4b_sum", 32'(b_sum_out), 31);
    chk("t4b_bytes", 32'(b_byte_cnt), 4);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
